data_pattern_gen: RTL and testbench

Upstream source stage for the clock/reset/data fan-out stage. It stretches the system reset into a clean `rst_out` for downstream consumers, then produces bursts of 16-bit test words on `data` under a valid/ready handshake. Word sequences are either incrementing-counter or LFSR sequences. It sits directly before the fan-out stage and drives both its reset and its data input.

---
 rtl/data_pattern_gen_pkg.sv | 18 +
 rtl/data_pattern_gen_if.sv | 23 ++
 rtl/data_pattern_gen_rst_stretch.sv | 39 +++
 rtl/data_pattern_gen.sv | 128 ++++++++++++
 tb/tb_data_pattern_gen.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/data_pattern_gen_pkg.sv
// Shared types and LFSR helper for the data pattern generator.
package patgen_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } patgen_state_e;

  // Taps at bits 15,13,12,10 for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] d);
    return {d[14:0], ^(d & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/data_pattern_gen_if.sv
// Burst request and word handshake bundle between the generator and its consumer.
interface data_pattern_gen_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic              mode;
  logic [7:0]        burst_len;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              busy;
  logic              done;

  modport master (
    input  start, mode, burst_len, ready,
    output data, valid, busy, done
  );

  modport slave (
    output start, mode, burst_len, ready,
    input  data, valid, busy, done
  );
endinterface

// File: rtl/data_pattern_gen_rst_stretch.sv
// Holds rst_out high for RST_HOLD cycles after rst drops; hold_done marks the release edge.
module patgen_rst_stretch #(
  parameter int unsigned RST_HOLD = 16
) (
  input  logic clk,
  input  logic rst,
  output logic rst_out,
  output logic hold_done
);
  logic [7:0] cnt_q, cnt_d;
  logic       rst_out_q, rst_out_d;

  assign hold_done = rst_out_q && (cnt_q == 8'(RST_HOLD));
  assign rst_out   = rst_out_q;

  // Count low-reset cycles until the hold expires, then drop rst_out
  always_comb begin
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
    if (hold_done) begin
      rst_out_d = 1'b0;
    end else if (rst_out_q) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 8'd0;
      rst_out_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
    end
  end
endmodule

// File: rtl/data_pattern_gen.sv
// Stretched-reset source plus counter/LFSR burst generator on a valid/ready handshake.
// Define PATGEN_LFSR_EN to compile in the LFSR mode; otherwise every burst is counter mode.
module data_pattern_gen
  import patgen_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int unsigned RST_HOLD = 16,
  parameter logic [15:0] SEED     = DEFAULT_SEED
) (
  input  logic                clk,
  input  logic                rst,
  output logic                rst_out,
  data_pattern_gen_if.master  bus
);
  localparam logic [1:0] S_HOLD = ST_HOLD;
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [8:0]        rem_q, rem_d;
  logic              mode_q, mode_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hold_done_s;
  logic              start_mode_s;
  logic [15:0]       seed_s;
  logic [DATA_W-1:0] next_word_s;

  patgen_rst_stretch #(.RST_HOLD(RST_HOLD)) u_rst_stretch (
    .clk       (clk),
    .rst       (rst),
    .rst_out   (rst_out),
    .hold_done (hold_done_s)
  );

`ifdef PATGEN_LFSR_EN
  assign start_mode_s = bus.mode;
  assign seed_s       = (SEED == 16'h0000) ? 16'h0001 : SEED;
  assign next_word_s  = mode_q ? lfsr_next(word_q) : (word_q + 16'd1);
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^{bus.mode, mode_q, SEED};
  assign start_mode_s = 1'b0;
  assign seed_s       = 16'h0000;
  assign next_word_s  = word_q + 16'd1;
`endif

  // Burst FSM: accept start in IDLE, advance on each handshake, pulse done after the last one
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (hold_done_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          mode_d  = start_mode_s;
          rem_d   = (bus.burst_len == 8'd0) ? 9'd256 : {1'b0, bus.burst_len};
          word_d  = start_mode_s ? seed_s : 16'h0000;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (valid_q && bus.ready) begin
          word_d = next_word_s;
          rem_d  = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_HOLD;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any burst without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HOLD;
      word_q  <= 16'h0000;
      rem_q   <= 9'd0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.data  = word_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_data_pattern_gen.sv
// Directed, table-driven bench for data_pattern_gen with hand-computed expectations.
module tb_data_pattern_gen;
  logic clk = 1'b0;
  logic rst;
  logic rst_out;
  int   total = 0;
  int   bad   = 0;

  data_pattern_gen_if bus();

  data_pattern_gen dut (
    .clk     (clk),
    .rst     (rst),
    .rst_out (rst_out),
    .bus     (bus)
  );

  always #5 clk = ~clk;

`ifdef PATGEN_LFSR_EN
  localparam logic [15:0] L0 = 16'hACE1;
  localparam logic [15:0] L1 = 16'h59C3;
  localparam logic [15:0] L2 = 16'hB387;
`else
  localparam logic [15:0] L0 = 16'h0000;
  localparam logic [15:0] L1 = 16'h0001;
  localparam logic [15:0] L2 = 16'h0002;
`endif

  typedef struct {
    logic        start;
    logic        mode;
    logic [7:0]  len;
    logic        ready;
    logic        e_valid;
    logic        e_busy;
    logic        e_done;
    logic        chk_data;
    logic [15:0] e_data;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic s, input logic m, input logic [7:0] l, input logic r,
                              input logic v, input logic b, input logic d,
                              input logic cd, input logic [15:0] ed);
    vec_t t;
    t.start = s; t.mode = m; t.len = l; t.ready = r;
    t.e_valid = v; t.e_busy = b; t.e_done = d; t.chk_data = cd; t.e_data = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic m, input logic [7:0] l, input logic r);
    bus.start = s; bus.mode = m; bus.burst_len = l; bus.ready = r;
  endtask

  initial begin
    // counter burst, no backpressure
    vecs[0]  = mk(1'b1, 1'b0, 8'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
    vecs[1]  = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001);
    vecs[2]  = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002);
    vecs[3]  = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0003);
    vecs[4]  = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    vecs[5]  = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    // counter burst with ready low for 3 cycles on word 0002
    vecs[6]  = mk(1'b1, 1'b0, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
    vecs[7]  = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001);
    vecs[8]  = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002);
    vecs[9]  = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002);
    vecs[10] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002);
    vecs[11] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002);
    vecs[12] = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0003);
    vecs[13] = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    vecs[14] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    // LFSR burst; start held high while running must be ignored
    vecs[15] = mk(1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, L0);
    vecs[16] = mk(1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, L1);
    vecs[17] = mk(1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, L2);
    vecs[18] = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    vecs[19] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    // back-to-back bursts: start accepted in the done cycle
    vecs[20] = mk(1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
    vecs[21] = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001);
    vecs[22] = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    vecs[23] = mk(1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
    vecs[24] = mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    vecs[25] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    rst = 1'b1;
    set_in(1'b0, 1'b0, 8'd0, 1'b0);
    repeat (3) step();
    chk("reset rst_out", 32'(rst_out), 32'd1);
    chk("reset data", 32'(bus.data), 32'h0000);
    chk("reset valid", 32'(bus.valid), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);

    // release: edge 0 is the first edge with rst low, rst_out falls at edge 16
    rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      step();
      chk($sformatf("release rst_out edge%0d", k), 32'(rst_out), (k < 16) ? 32'd1 : 32'd0);
      chk($sformatf("release valid edge%0d", k), 32'(bus.valid), 32'd0);
    end

    for (int i = 0; i < 26; i++) begin
      set_in(vecs[i].start, vecs[i].mode, vecs[i].len, vecs[i].ready);
      step();
      chk($sformatf("row%0d valid", i), 32'(bus.valid), 32'(vecs[i].e_valid));
      chk($sformatf("row%0d busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
      chk($sformatf("row%0d done", i), 32'(bus.done), 32'(vecs[i].e_done));
      if (vecs[i].chk_data) begin
        chk($sformatf("row%0d data", i), 32'(bus.data), 32'(vecs[i].e_data));
      end
    end

    // burst_len 0 means 256 words 0000..00FF
    set_in(1'b1, 1'b0, 8'd0, 1'b1);
    step();
    set_in(1'b0, 1'b0, 8'd0, 1'b1);
    for (int w = 0; w < 256; w++) begin
      chk($sformatf("len0 word%0d", w), {15'd0, bus.valid, bus.data}, {15'd0, 1'b1, 16'(w)});
      step();
    end
    chk("len0 done", 32'(bus.done), 32'd1);
    chk("len0 valid end", 32'(bus.valid), 32'd0);
    set_in(1'b0, 1'b0, 8'd0, 1'b0);
    step();

    // reset pulse on the second word of an 8-word burst
    set_in(1'b1, 1'b0, 8'd8, 1'b1);
    step();
    set_in(1'b0, 1'b0, 8'd0, 1'b1);
    step();
    chk("mid second word", 32'(bus.data), 32'h0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid rst valid", 32'(bus.valid), 32'd0);
    chk("mid rst rst_out", 32'(rst_out), 32'd1);
    chk("mid rst done", 32'(bus.done), 32'd0);
    chk("mid rst data", 32'(bus.data), 32'h0000);
    set_in(1'b1, 1'b0, 8'd1, 1'b1);
    for (int k = 0; k <= 16; k++) begin
      step();
      chk($sformatf("mid hold rst_out edge%0d", k), 32'(rst_out), (k < 16) ? 32'd1 : 32'd0);
      chk($sformatf("mid hold valid/done edge%0d", k), {30'd0, bus.valid, bus.done}, 32'd0);
    end
    step();
    set_in(1'b0, 1'b0, 8'd0, 1'b1);
    chk("mid restart valid", 32'(bus.valid), 32'd1);
    chk("mid restart data", 32'(bus.data), 32'h0000);
    step();
    chk("mid restart done", 32'(bus.done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
